// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue between dispatch, the CDBs and memory.
// Circular buffer with per-entry operand snooping and commit tracking. Stores drain
// only after ROB commit. A flush keeps the committed run at the head.
// Optional: define LSB_IO_GUARD_EN to make head loads to I/O space (addr[17:16] == 2'b11)
// wait for commit like stores.
module load_store_queue #(
    parameter int DEPTH = 16,
    parameter int ROB_W = 5,
    parameter int NCDB  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  dispatch_valid,
    input  logic                  dispatch_store,
    input  logic [2:0]            dispatch_funct3,
    input  logic [31:0]           dispatch_imm,
    input  logic [ROB_W-1:0]      dispatch_Qi,
    input  logic [ROB_W-1:0]      dispatch_Qj,
    input  logic [31:0]           dispatch_Vi,
    input  logic [31:0]           dispatch_Vj,
    input  logic [ROB_W-1:0]      dispatch_rob_id,
    output logic                  lsb_full,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
    input  logic [NCDB*32-1:0]    cdb_res,
    input  logic                  rob_commit_valid,
    input  logic [ROB_W-1:0]      rob_commit_id,
    input  logic                  wrong_commit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [2:0]            mem_size,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_rdata,
    output logic                  lsb_valid,
    output logic [31:0]           lsb_res,
    output logic [ROB_W-1:0]      lsb_rob_id
);
    localparam int PW  = $clog2(DEPTH);
    localparam int NCH = NCDB + 1;  // CDB channels plus our own load-result broadcast

    typedef struct packed {
        logic             store;
        logic [2:0]       f3;
        logic [31:0]      imm;
        logic [ROB_W-1:0] qi;
        logic [31:0]      vi;
        logic [ROB_W-1:0] qj;
        logic [31:0]      vj;
        logic [ROB_W-1:0] rob;
        logic             cmt;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST, DRAIN} state_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, off;
    logic [PW:0]      cnt_q, cnt_d, run;
    state_t           state_q, state_d;

    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [2:0]       mem_size_q, mem_size_d, ld_f3_q, ld_f3_d;
    logic             lsb_valid_q, lsb_valid_d;
    logic [31:0]      lsb_res_q, lsb_res_d;
    logic [ROB_W-1:0] lsb_rob_q, lsb_rob_d, ld_rob_q, ld_rob_d;

    logic [NCH-1:0]            ch_vld;
    logic [NCH-1:0][ROB_W-1:0] ch_tag;
    logic [NCH-1:0][31:0]      ch_val;

    entry_t      hd;
    logic [31:0] hd_addr;
    logic        hd_cmt, hd_gate, issue, enq, brk;

    // Resolve a tag against all channels; iterate downward so the lowest index wins.
    function automatic logic [ROB_W+31:0] snoop(input logic [ROB_W-1:0] q, input logic [31:0] v,
                                                input logic [NCH-1:0] vld,
                                                input logic [NCH-1:0][ROB_W-1:0] tag,
                                                input logic [NCH-1:0][31:0] val);
        logic [ROB_W+31:0] r;
        r = {q, v};
        if (q != '0)
            for (int k = NCH-1; k >= 0; k--)
                if (vld[k] && tag[k] == q) r = {{ROB_W{1'b0}}, val[k]};
        return r;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  ext = {{24{d[7]}}, d[7:0]};
            3'b001:  ext = {{16{d[15]}}, d[15:0]};
            3'b100:  ext = {24'b0, d[7:0]};
            3'b101:  ext = {16'b0, d[15:0]};
            default: ext = d;
        endcase
    endfunction

    function automatic logic [2:0] sz(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   sz = 3'b001;
            2'b01:   sz = 3'b010;
            default: sz = 3'b100;
        endcase
    endfunction

    // Gather snooped channels; own result sits at the highest (lowest-priority) index.
    always_comb begin
        ch_vld = {lsb_valid_q, cdb_valid};
        ch_tag = {lsb_rob_q, cdb_rob_id};
        ch_val = {lsb_res_q, cdb_res};
    end

    // Head eligibility; nothing issues or enqueues in a flush cycle.
    always_comb begin
        hd      = ent_q[head_q];
        hd_addr = hd.vi + hd.imm;
        hd_cmt  = hd.cmt || (rob_commit_valid && rob_commit_id == hd.rob);
`ifdef LSB_IO_GUARD_EN
        hd_gate = hd.store || (hd_addr[17:16] == 2'b11);
`else
        hd_gate = hd.store;
`endif
        issue = (state_q == IDLE) && !wrong_commit && (cnt_q != '0) &&
                (hd.qi == '0) && (hd.qj == '0) && (!hd_gate || hd_cmt);
        enq   = dispatch_valid && !lsb_full && !wrong_commit;
    end

    // Queue next state: flush truncation, or snoop/commit/enqueue/pop.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        run    = '0;
        brk    = 1'b0;
        off    = '0;
        if (wrong_commit) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!brk && ((PW+1)'(k) < cnt_q) && ent_q[head_q + PW'(k)].cmt) run = run + (PW+1)'(1);
                else brk = 1'b1;
            end
            tail_d = head_q + run[PW-1:0];
            cnt_d  = run;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - head_q;
                if ({1'b0, off} < cnt_q) begin
                    {ent_d[i].qi, ent_d[i].vi} = snoop(ent_q[i].qi, ent_q[i].vi, ch_vld, ch_tag, ch_val);
                    {ent_d[i].qj, ent_d[i].vj} = snoop(ent_q[i].qj, ent_q[i].vj, ch_vld, ch_tag, ch_val);
                    if (rob_commit_valid && ent_q[i].rob == rob_commit_id) ent_d[i].cmt = 1'b1;
                end
            end
            if (enq) begin
                ent_d[tail_q].store = dispatch_store;
                ent_d[tail_q].f3    = dispatch_funct3;
                ent_d[tail_q].imm   = dispatch_imm;
                ent_d[tail_q].rob   = dispatch_rob_id;
                ent_d[tail_q].cmt   = 1'b0;
                {ent_d[tail_q].qi, ent_d[tail_q].vi} = snoop(dispatch_Qi, dispatch_Vi, ch_vld, ch_tag, ch_val);
                {ent_d[tail_q].qj, ent_d[tail_q].vj} = snoop(dispatch_Qj, dispatch_Vj, ch_vld, ch_tag, ch_val);
                tail_d = tail_q + PW'(1);
            end
            if (issue) head_d = head_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(enq) - (PW+1)'(issue);
        end
    end

    // FSM next state; a flushed in-flight load drains its response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = hd.store ? WAIT_ST : WAIT_LD;
            WAIT_LD: if (mem_valid) state_d = IDLE;
                     else if (wrong_commit) state_d = DRAIN;
            WAIT_ST: if (mem_valid) state_d = IDLE;
            DRAIN:   if (mem_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: launch request on issue, retire on mem_valid, broadcast loads.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        ld_f3_d     = ld_f3_q;
        ld_rob_d    = ld_rob_q;
        lsb_valid_d = 1'b0;
        lsb_res_d   = lsb_res_q;
        lsb_rob_d   = lsb_rob_q;
        if (issue) begin
            mem_req_d   = 1'b1;
            mem_we_d    = hd.store;
            mem_addr_d  = hd_addr;
            mem_wdata_d = hd.vj;
            mem_size_d  = sz(hd.f3);
            ld_f3_d     = hd.f3;
            ld_rob_d    = hd.rob;
        end
        if (state_q != IDLE && mem_valid) begin
            mem_req_d = 1'b0;
            // A load whose flush coincides with its response is dropped too.
            if (state_q == WAIT_LD && !wrong_commit) begin
                lsb_valid_d = 1'b1;
                lsb_res_d   = ext(ld_f3_q, mem_rdata);
                lsb_rob_d   = ld_rob_q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     state_q <= IDLE;
        else if (rdy) state_q <= state_d;
    end

    // Queue and output registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            ld_f3_q     <= '0;
            ld_rob_q    <= '0;
            lsb_valid_q <= 1'b0;
            lsb_res_q   <= '0;
            lsb_rob_q   <= '0;
        end else if (rdy) begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            ld_f3_q     <= ld_f3_d;
            ld_rob_q    <= ld_rob_d;
            lsb_valid_q <= lsb_valid_d;
            lsb_res_q   <= lsb_res_d;
            lsb_rob_q   <= lsb_rob_d;
        end
    end

    assign lsb_full   = (cnt_q == (PW+1)'(DEPTH));
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_size   = mem_size_q;
    assign lsb_valid  = lsb_valid_q;
    assign lsb_res    = lsb_res_q;
    assign lsb_rob_id = lsb_rob_q;
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: load path, extension, store gating, snooping,
// flush with committed stores and an in-flight load, full/wrap FIFO order.
module tb_load_store_queue;
    localparam int DEPTH = 16, ROB_W = 5, NCDB = 2;

    logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic dispatch_valid = 0, dispatch_store = 0;
    logic [2:0] dispatch_funct3 = '0;
    logic [31:0] dispatch_imm = '0, dispatch_Vi = '0, dispatch_Vj = '0;
    logic [ROB_W-1:0] dispatch_Qi = '0, dispatch_Qj = '0, dispatch_rob_id = '0;
    logic lsb_full;
    logic [NCDB-1:0] cdb_valid = '0;
    logic [NCDB*ROB_W-1:0] cdb_rob_id = '0;
    logic [NCDB*32-1:0] cdb_res = '0;
    logic rob_commit_valid = 0, wrong_commit = 0, mem_valid = 0;
    logic [ROB_W-1:0] rob_commit_id = '0;
    logic mem_req, mem_we, lsb_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, lsb_res;
    logic [2:0] mem_size;
    logic [ROB_W-1:0] lsb_rob_id;

    int n_chk = 0, n_pass = 0;

    load_store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NCDB(NCDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dispatch_valid(dispatch_valid), .dispatch_store(dispatch_store),
        .dispatch_funct3(dispatch_funct3), .dispatch_imm(dispatch_imm),
        .dispatch_Qi(dispatch_Qi), .dispatch_Qj(dispatch_Qj),
        .dispatch_Vi(dispatch_Vi), .dispatch_Vj(dispatch_Vj),
        .dispatch_rob_id(dispatch_rob_id), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_res(cdb_res),
        .rob_commit_valid(rob_commit_valid), .rob_commit_id(rob_commit_id),
        .wrong_commit(wrong_commit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .lsb_valid(lsb_valid), .lsb_res(lsb_res), .lsb_rob_id(lsb_rob_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] vi, input logic [31:0] vj,
                        input logic [4:0] qi, input logic [4:0] qj, input logic [4:0] rob);
        dispatch_valid = 1; dispatch_store = st; dispatch_funct3 = f3; dispatch_imm = imm;
        dispatch_Vi = vi; dispatch_Vj = vj; dispatch_Qi = qi; dispatch_Qj = qj; dispatch_rob_id = rob;
        tick();
        dispatch_valid = 0;
    endtask

    task automatic resp(input logic [31:0] d);
        mem_valid = 1; mem_rdata = d;
        tick();
        mem_valid = 0;
    endtask

    task automatic commit(input logic [4:0] id);
        rob_commit_valid = 1; rob_commit_id = id;
        tick();
        rob_commit_valid = 0;
    endtask

    task automatic flush();
        wrong_commit = 1;
        tick();
        wrong_commit = 0;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!mem_req && n < max) begin tick(); n++; end
        chk("req_timeout", mem_req, 1);
    endtask

    task automatic ld_ext(input logic [2:0] f3, input logic [4:0] rob, input logic [31:0] d,
                          input logic [2:0] esz, input logic [31:0] exp);
        disp(0, f3, 32'h0, 32'h40, 32'h0, 0, 0, rob);
        tick();
        chk("ext_req", mem_req, 1);
        chk("ext_size", mem_size, esz);
        resp(d);
        chk("ext_valid", lsb_valid, 1);
        chk("ext_res", lsb_res, exp);
        tick();
    endtask

    // Fill to DEPTH behind a blocked head, try one extra, release, drain in order.
    task automatic fill_drain(input logic [31:0] base);
        disp(0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd30, 0, 5'd1);
        for (int k = 1; k < DEPTH; k++) begin
            if (k == DEPTH-1) chk("fill_not_full", lsb_full, 0);
            disp(0, 3'b010, 32'(4*k), base, 32'h0, 0, 0, 5'(k+1));
        end
        chk("fill_full", lsb_full, 1);
        disp(0, 3'b010, 32'h0, 32'hDEAD0000, 32'h0, 0, 0, 5'd17);
        chk("full_ignored", lsb_full, 1);
        chk("blocked_head", mem_req, 0);
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd30}; cdb_res = {32'h0, base};
        tick();
        cdb_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wait_req(6);
            chk("wrap_addr", mem_addr, base + 32'(4*k));
            resp(32'(k));
            chk("wrap_rob", lsb_rob_id, 32'(k+1));
        end
        repeat (3) tick();
        chk("wrap_empty", mem_req, 0);
    endtask

    initial begin
        // reset
        tick(); tick();
        chk("rst_req", mem_req, 0);
        chk("rst_full", lsb_full, 0);
        chk("rst_valid", lsb_valid, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1;
        tick();

        // basic load, plus a dependent load resolved by our own broadcast
        disp(0, 3'b010, 32'h4, 32'h100, 32'h0, 0, 0, 5'd1);
        chk("ld_req_early", mem_req, 0);
        tick();
        chk("ld_req", mem_req, 1);
        chk("ld_addr", mem_addr, 32'h104);
        chk("ld_size", mem_size, 3'b100);
        chk("ld_we", mem_we, 0);
        disp(0, 3'b010, 32'h8, 32'h0, 32'h0, 5'd1, 0, 5'd2);
        tick();
        chk("ld_req_hold", mem_req, 1);
        resp(32'h8000_00F0);
        chk("ld_req_drop", mem_req, 0);
        chk("ld_valid", lsb_valid, 1);
        chk("ld_res", lsb_res, 32'h8000_00F0);
        chk("ld_rob", lsb_rob_id, 1);
        tick();
        chk("ld_pulse", lsb_valid, 0);
        wait_req(4);
        chk("own_snoop_addr", mem_addr, 32'h8000_00F8);
        resp(32'h5);
        chk("own_snoop_rob", lsb_rob_id, 2);
        tick();

        // extension
        ld_ext(3'b000, 5'd4, 32'h0000_0080, 3'b001, 32'hFFFF_FF80);
        ld_ext(3'b100, 5'd5, 32'h0000_0080, 3'b001, 32'h0000_0080);
        ld_ext(3'b001, 5'd6, 32'h0000_8001, 3'b010, 32'hFFFF_8001);

        // store gating
        disp(1, 3'b010, 32'h8, 32'h300, 32'hDEADBEEF, 0, 0, 5'd3);
        repeat (3) tick();
        chk("st_gated", mem_req, 0);
        commit(5'd3);
        chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 32'h308);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        resp(32'h0);
        chk("st_done", mem_req, 0);
        chk("st_no_bcast", lsb_valid, 0);

        // dispatch bypass: ch0 unrelated, ch1 matches
        cdb_valid = 2'b11; cdb_rob_id = {5'd7, 5'd9}; cdb_res = {32'h200, 32'h999};
        disp(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd7, 0, 5'd4);
        cdb_valid = '0;
        tick();
        chk("byp_addr", mem_addr, 32'h210);
        resp(32'h0);
        // queued snoop, both channels match: lowest index wins
        disp(0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd6, 0, 5'd5);
        tick();
        chk("snp_wait", mem_req, 0);
        cdb_valid = 2'b11; cdb_rob_id = {5'd6, 5'd6}; cdb_res = {32'h500, 32'h400};
        tick();
        cdb_valid = '0;
        tick();
        chk("snp_req", mem_req, 1);
        chk("snp_prio_addr", mem_addr, 32'h400);
        resp(32'h0);

        // flush: in-flight LW, committed SW/SB, uncommitted LW
        disp(0, 3'b010, 32'h0, 32'h700, 32'h0, 0, 0, 5'd10);
        disp(1, 3'b010, 32'h0, 32'h500, 32'h11112222, 0, 0, 5'd11);
        chk("fl_ld_addr", mem_addr, 32'h700);
        disp(1, 3'b000, 32'h1, 32'h600, 32'h33, 0, 0, 5'd12);
        disp(0, 3'b010, 32'h0, 32'h900, 32'h0, 0, 0, 5'd13);
        commit(5'd11);
        commit(5'd12);
        flush();
        for (int k = 0; k < DEPTH-2; k++) begin
            if (k == DEPTH-3) chk("fl_cnt_lo", lsb_full, 0);
            disp(1, 3'b010, 32'h0, 32'hBAD0, 32'h0, 0, 0, 5'(20+k));
        end
        chk("fl_cnt_full", lsb_full, 1);
        flush();
        chk("fl2_not_full", lsb_full, 0);
        resp(32'h1234_5678);
        chk("fl_drain_req", mem_req, 0);
        chk("fl_drain_drop", lsb_valid, 0);
        tick();
        chk("fl_sw_req", mem_req, 1);
        chk("fl_sw_we", mem_we, 1);
        chk("fl_sw_addr", mem_addr, 32'h500);
        chk("fl_sw_wdata", mem_wdata, 32'h11112222);
        resp(32'h0);
        chk("fl_sw_nobc", lsb_valid, 0);
        tick();
        chk("fl_sb_req", mem_req, 1);
        chk("fl_sb_addr", mem_addr, 32'h601);
        chk("fl_sb_size", mem_size, 3'b001);
        chk("fl_sb_wdata", mem_wdata, 32'h33);
        resp(32'h0);
        repeat (3) tick();
        chk("fl_discarded", mem_req, 0);

        // full and wrap, twice through the ring
        fill_drain(32'h1000);
        fill_drain(32'h2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
